// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential 2W-by-W restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Ceiling log2 with a floor of 1 so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit and trial-subtract.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   r,
  input  logic         q_msb,
  input  logic [W-1:0] b,
  output logic [W:0]   r_next,
  output logic         q_bit
);

  logic [W+1:0] shifted;
  logic [W:0]   diff;

  always_comb begin
    shifted = {r, q_msb};
    q_bit   = (shifted >= {2'b00, b});
    // When the subtraction succeeds the result is below b, so W+1 bits cannot wrap.
    diff    = shifted[W:0] - {1'b0, b};
    r_next  = q_bit ? diff : shifted[W:0];
  end

endmodule

// File: rtl/seq_div_2w_by_w.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, one step per clock,
// valid/ready handshakes on both sides and a single operation in flight.
module seq_div_2w_by_w
  import div_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem,
  output logic           dz,
  output logic           ovf
);

  localparam int unsigned CntW = clog2(W);

  div_state_e    state;
  logic [W:0]    r_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  b_q;
  logic [CntW-1:0] cnt;

  logic [W-1:0]  a_hi;
  logic [W-1:0]  a_lo;
  logic [W:0]    r_next;
  logic          q_bit;
  logic [W-1:0]  q_shift;

  assign a_hi    = a[2*W-1:W];
  assign a_lo    = a[W-1:0];
  assign q_shift = (q_q << 1) | {{(W-1){1'b0}}, q_bit};

  div_step #(
    .W (W)
  ) u_step (
    .r      (r_q),
    .q_msb  (q_q[W-1]),
    .b      (b_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      r_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            b_q      <= b;
            dz       <= 1'b0;
            ovf      <= 1'b0;
            if (b == '0) begin
              quot  <= '1;
              rem   <= a_lo;
              dz    <= 1'b1;
              state <= DONE;
            end else if (a_hi >= b) begin
              // Quotient would need more than W bits.
              quot  <= '1;
              rem   <= '0;
              ovf   <= 1'b1;
              state <= DONE;
            end else begin
              r_q   <= {1'b0, a_hi};
              q_q   <= a_lo;
              cnt   <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          r_q <= r_next;
          q_q <= q_shift;
          cnt <= cnt + 1'b1;
          if (cnt == CntW'(W - 1)) begin
            quot  <= q_shift;
            rem   <= r_next[W-1:0];
            state <= DONE;
          end
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE, then waits for the handshake.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_2w_by_w.sv
// Self-checking bench for seq_div_2w_by_w: directed cases, backpressure, mid-op reset, random sweep.
module tb_seq_div_2w_by_w;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  a;
  logic [7:0]   b;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   quot;
  logic [7:0]   rem;
  logic         dz;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_div_2w_by_w #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dz        (dz),
    .ovf       (ovf)
  );

  // Reference: plain integer division plus the two special classifications.
  task automatic model(input logic [15:0] av, input logic [7:0] bv,
                       output logic [7:0] eq, output logic [7:0] er,
                       output logic edz, output logic eovf, output int elat);
    int unsigned ai, bi;
    ai = av;
    bi = bv;
    edz = 1'b0;
    eovf = 1'b0;
    if (bi == 0) begin
      eq = 8'hFF; er = av[7:0]; edz = 1'b1; elat = 1;
    end else if ((ai / 256) >= bi) begin
      eq = 8'hFF; er = 8'h00; eovf = 1'b1; elat = 1;
    end else begin
      eq = 8'(ai / bi); er = 8'(ai % bi); elat = W + 1;
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_op(input logic [15:0] av, input logic [7:0] bv,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic fdz, output logic fovf, output int lat);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quot; r = rem; fdz = dz; fovf = ovf;
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end else begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if ({quot, rem} !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", {quot, rem}); end
    n_tests++; if ({dz, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {dz, ovf}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [15:0] av [4] = '{16'h1234, 16'hFE01, 16'h1234, 16'hFFFF};
    logic [7:0]  bv [4] = '{8'h56,    8'hFF,    8'h00,    8'hFF};
    logic [7:0]  xq [4] = '{8'h36,    8'hFF,    8'hFF,    8'hFF};
    logic [7:0]  xr [4] = '{8'h10,    8'h00,    8'h34,    8'h00};
    logic [1:0]  xf [4] = '{2'b00,    2'b00,    2'b10,    2'b01};
    int          xl [4] = '{9,        9,        1,        1};
    logic [7:0] q, r;
    logic fdz, fovf;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], q, r, fdz, fovf, lat);
      n_tests++; if (q !== xq[i]) begin n_fail++; $display("FAIL dir%0d_quot: got %h want %h", i, q, xq[i]); end
      n_tests++; if (r !== xr[i]) begin n_fail++; $display("FAIL dir%0d_rem: got %h want %h", i, r, xr[i]); end
      n_tests++; if ({fdz, fovf} !== xf[i]) begin n_fail++; $display("FAIL dir%0d_flags: got %b want %b", i, {fdz, fovf}, xf[i]); end
      n_tests++; if (lat !== xl[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, xl[i]); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    a = 16'h1234; b = 8'h56; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin a = 16'h0064; b = 8'h07; in_valid = 1'b1; end
      else in_valid = 1'b0;
      n_tests++;
      if ({out_valid, in_ready, quot, rem, dz, ovf} !== {2'b10, 8'h36, 8'h10, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b r=%b q=%h rm=%h f=%b want v=1 r=0 q=36 rm=10 f=00",
                 c, out_valid, in_ready, quot, rem, {dz, ovf});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    @(posedge clk); #1;
    n_tests++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_ignored_pulse: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] q, r;
    logic fdz, fovf;
    int lat;
    a = 16'h1234; b = 8'h56; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, in_ready, quot, rem, dz, ovf} !== {2'b01, 16'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b r=%b q=%h rm=%h f=%b want v=0 r=1 q=00 rm=00 f=00",
               out_valid, in_ready, quot, rem, {dz, ovf});
    end
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 12; c++) begin
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_fail++; $display("FAIL midrst_no_result%0d: got v=%b r=%b want v=0 r=1", c, out_valid, in_ready);
      end
      @(posedge clk); #1;
    end
    run_op(16'h0064, 8'h07, q, r, fdz, fovf, lat);
    n_tests++; if ({q, r, fdz, fovf} !== {8'h0E, 8'h02, 2'b00}) begin n_fail++; $display("FAIL midrst_next: got q=%h r=%h f=%b want q=0e r=02 f=00", q, r, {fdz, fovf}); end
  endtask

  task automatic test_random();
    logic [15:0] av;
    logic [7:0]  bv, hi, eq, er, q, r;
    logic        edz, eovf, fdz, fovf;
    int          elat, lat;
    int unsigned sel;
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        bv = 8'h00; av = 16'($urandom);
      end else if (sel == 1) begin
        bv = 8'($urandom_range(1, 255));
        hi = 8'($urandom_range(bv, 255));
        av = {hi, 8'($urandom)};
      end else begin
        bv = 8'($urandom_range(1, 255));
        hi = 8'($urandom_range(0, bv - 1));
        av = {hi, 8'($urandom)};
      end
      model(av, bv, eq, er, edz, eovf, elat);
      run_op(av, bv, q, r, fdz, fovf, lat);
      n_tests++;
      if ({q, r, fdz, fovf} !== {eq, er, edz, eovf} || lat != elat) begin
        n_fail++;
        $display("FAIL rand%0d a=%h b=%h: got q=%h r=%h dz=%b ovf=%b lat=%0d want q=%h r=%h dz=%b ovf=%b lat=%0d",
                 i, av, bv, q, r, fdz, fovf, lat, eq, er, edz, eovf, elat);
      end
      if (!edz && !eovf) begin
        n_tests++;
        if ((32'(q) * 32'(bv) + 32'(r)) != 32'(av) || r >= bv) begin
          n_fail++;
          $display("FAIL rand%0d_invariant a=%h b=%h: got q=%h r=%h want a==q*b+r, r<b", i, av, bv, q, r);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
